// File: rtl/steer_queue_if.sv
// Fetch/dispatch bundle for steer_queue: fetch pair in, two-slot dispatch group out.
interface steer_queue_if #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
);
    logic                  in_valid0;
    logic                  in_valid1;
    logic [INST_WIDTH-1:0] inst0_in;
    logic [INST_WIDTH-1:0] inst1_in;
    logic                  in_ready;
    logic                  stall;
    logic                  flush;
    logic [INST_WIDTH-1:0] instruction0_out;
    logic [INST_WIDTH-1:0] instruction1_out;
    logic                  valid0_out;
    logic                  valid1_out;
    logic                  first;
    logic [CNT_W-1:0]      occupancy;

    modport master (
        output in_valid0, in_valid1, inst0_in, inst1_in, stall, flush,
        input  in_ready, instruction0_out, instruction1_out, valid0_out, valid1_out,
               first, occupancy
    );

    modport slave (
        input  in_valid0, in_valid1, inst0_in, inst1_in, stall, flush,
        output in_ready, instruction0_out, instruction1_out, valid0_out, valid1_out,
               first, occupancy
    );
endinterface

// File: rtl/steer_queue.sv
// Dual-issue steering queue: pipe A (slot 0) takes BR/ALU, pipe B (slot 1) takes MEM/ALU.
// Optional macro STEER_QUEUE_NOP_SQUASH_EN drops opcode-000000 instructions at enqueue.
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0000
`endif
`ifndef OP_CODE_CMP
`define OP_CODE_CMP 6'b000010
`endif
`ifndef OP_CODE_TEST
`define OP_CODE_TEST 6'b000011
`endif
`ifndef OP_CODE_CMPI
`define OP_CODE_CMPI 6'b010010
`endif
`ifndef OP_CODE_TESTI
`define OP_CODE_TESTI 6'b010011
`endif

module steer_queue #(
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned OPCODE_MSB = 31,
    parameter int unsigned OPCODE_LSB = 26,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input logic        clk,
    input logic        rst_n,
    steer_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(`NOP_INSTRUCTION);

    typedef enum logic [1:0] {ClsDc, ClsBr, ClsMem} cls_e;

    function automatic cls_e classify(input logic [INST_WIDTH-1:0] inst);
        logic [5:0] op;
        cls_e       cls;
        op = inst[OPCODE_MSB:OPCODE_LSB];
        case (op[5:4])
            2'b00:   cls = (op == `OP_CODE_CMP  || op == `OP_CODE_TEST)  ? ClsBr : ClsDc;
            2'b01:   cls = (op == `OP_CODE_CMPI || op == `OP_CODE_TESTI) ? ClsBr : ClsDc;
            2'b10:   cls = ClsMem;
            default: cls = ClsBr;
        endcase
        return cls;
    endfunction

    logic [INST_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q, wr_ptr1;
    logic [CNT_W-1:0]      occ_q, push_cnt, pop_cnt, pop_eff;
    logic [INST_WIDTH-1:0] inst0_q, inst1_q, sel0, sel1, h0, h1;
    logic                  valid0_q, valid1_q, first_q, sv0, sv1, sel_first;
    logic                  in_ready, nop0, nop1, push0, push1;
    cls_e                  c0, c1;

`ifdef STEER_QUEUE_NOP_SQUASH_EN
    assign nop0 = (bus.inst0_in[OPCODE_MSB:OPCODE_LSB] == '0);
    assign nop1 = (bus.inst1_in[OPCODE_MSB:OPCODE_LSB] == '0);
`else
    assign nop0 = 1'b0;
    assign nop1 = 1'b0;
`endif

    // No same-cycle credit for a pop: room is judged on pre-edge occupancy only.
    assign in_ready = (occ_q <= CNT_W'(DEPTH - 2));
    assign push0    = in_ready & bus.in_valid0 & ~nop0;
    assign push1    = in_ready & bus.in_valid0 & bus.in_valid1 & ~nop1;
    assign push_cnt = CNT_W'(push0) + CNT_W'(push1);
    assign wr_ptr1  = wr_ptr_q + PTR_W'(push0);

    assign h0 = mem_q[rd_ptr_q];
    assign h1 = mem_q[rd_ptr_q + PTR_W'(1)];
    assign c0 = classify(h0);
    assign c1 = classify(h1);

    always_comb begin
        sel0      = NOP;
        sel1      = NOP;
        sv0       = 1'b0;
        sv1       = 1'b0;
        sel_first = 1'b0;
        pop_cnt   = '0;
        if (occ_q >= CNT_W'(2) && !(c0 == c1 && c0 != ClsDc)) begin
            pop_cnt = CNT_W'(2);
            sv0     = 1'b1;
            sv1     = 1'b1;
            // Swap when the older one cannot sit in slot 0 or the younger cannot sit in slot 1.
            if ((c0 == ClsMem && c1 != ClsMem) || (c0 == ClsDc && c1 == ClsBr)) begin
                sel0      = h1;
                sel1      = h0;
                sel_first = 1'b1;
            end else begin
                sel0 = h0;
                sel1 = h1;
            end
        end else if (occ_q != '0) begin
            pop_cnt = CNT_W'(1);
            if (c0 == ClsMem) begin
                sel1      = h0;
                sv1       = 1'b1;
                sel_first = 1'b1;
            end else begin
                sel0 = h0;
                sv0  = 1'b1;
            end
        end
    end

    assign pop_eff = bus.stall ? '0 : pop_cnt;

    always_ff @(posedge clk) begin
        if (!bus.flush && push0) mem_q[wr_ptr_q] <= bus.inst0_in;
        if (!bus.flush && push1) mem_q[wr_ptr1]  <= bus.inst1_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            inst0_q  <= NOP;
            inst1_q  <= NOP;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            first_q  <= 1'b0;
        end else if (bus.flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            inst0_q  <= NOP;
            inst1_q  <= NOP;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            first_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push_cnt);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_eff);
            occ_q    <= occ_q + push_cnt - pop_eff;
            if (!bus.stall) begin
                inst0_q  <= sel0;
                inst1_q  <= sel1;
                valid0_q <= sv0;
                valid1_q <= sv1;
                first_q  <= sel_first;
            end
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.instruction0_out = inst0_q;
    assign bus.instruction1_out = inst1_q;
    assign bus.valid0_out       = valid0_q;
    assign bus.valid1_out       = valid1_q;
    assign bus.first            = first_q;
    assign bus.occupancy        = occ_q;

    a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= CNT_W'(DEPTH));
    a_valid1_protocol: assert property (@(posedge clk) disable iff (!rst_n)
                                        !(bus.in_valid1 && !bus.in_valid0));
endmodule

// File: tb/tb_steer_queue.sv
// Bench for steer_queue: directed vector table, NOP-squash sequence, random run vs queue model.
module tb_steer_queue;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;
`ifdef STEER_QUEUE_NOP_SQUASH_EN
    localparam bit SQ = 1'b1;
`else
    localparam bit SQ = 1'b0;
`endif

    localparam logic [31:0] NOPI = 32'h0;
    localparam logic [31:0] ADD1 = {6'b000100, 26'd1};
    localparam logic [31:0] ADD2 = {6'b000100, 26'd2};
    localparam logic [31:0] ADD3 = {6'b000101, 26'd3};
    localparam logic [31:0] ADD4 = {6'b000101, 26'd4};
    localparam logic [31:0] LW   = {6'b100011, 26'd5};
    localparam logic [31:0] SW   = {6'b101011, 26'd6};
    localparam logic [31:0] JMP  = {6'b110000, 26'd7};
    localparam logic [31:0] CMP  = {6'b000010, 26'd8};
    localparam logic [31:0] JE   = {6'b110100, 26'd9};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    steer_queue_if #(.INST_WIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    steer_queue #(
        .INST_WIDTH(W), .OPCODE_MSB(31), .OPCODE_LSB(26), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic v1, input logic [31:0] i0,
                         input logic [31:0] i1, input logic st, input logic fl);
        bus.in_valid0 = v0;
        bus.in_valid1 = v1;
        bus.inst0_in  = i0;
        bus.inst1_in  = i1;
        bus.stall     = st;
        bus.flush     = fl;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic ev0, input logic ev1, input logic ef,
                           input logic [31:0] eocc, input logic erdy);
        chk({tag, ".i0"}, bus.instruction0_out, e0);
        chk({tag, ".i1"}, bus.instruction1_out, e1);
        chk({tag, ".v0"}, 32'(bus.valid0_out), 32'(ev0));
        chk({tag, ".v1"}, 32'(bus.valid1_out), 32'(ev1));
        chk({tag, ".first"}, 32'(bus.first), 32'(ef));
        chk({tag, ".occ"}, 32'(bus.occupancy), eocc);
        chk({tag, ".ready"}, 32'(bus.in_ready), 32'(erdy));
    endtask

    typedef struct {
        logic v0, v1; logic [31:0] i0, i1; logic st, fl;
        logic [31:0] e0, e1; logic ev0, ev1, ef; logic [31:0] eocc; logic erdy;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mkv(logic v0, logic v1, logic [31:0] i0, logic [31:0] i1,
                                 logic st, logic fl, logic [31:0] e0, logic [31:0] e1,
                                 logic ev0, logic ev1, logic ef, logic [31:0] eocc,
                                 logic erdy);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.i0 = i0; v.i1 = i1; v.st = st; v.fl = fl;
        v.e0 = e0; v.e1 = e1; v.ev0 = ev0; v.ev1 = ev1; v.ef = ef; v.eocc = eocc;
        v.erdy = erdy;
        return v;
    endfunction

    // Reference model: FIFO of instructions plus the dispatch registers.
    typedef enum int {KDc, KBr, KMem} kind_e;
    logic [31:0] mq[$];
    logic [31:0] m_i0, m_i1;
    logic        m_v0, m_v1, m_f;

    function automatic kind_e kind(input logic [31:0] inst);
        logic [5:0] op;
        op = inst[31:26];
        if (op[5:4] == 2'b10) return KMem;
        if (op[5:4] == 2'b11) return KBr;
        if (op == 6'b000010 || op == 6'b000011 || op == 6'b010010 || op == 6'b010011)
            return KBr;
        return KDc;
    endfunction

    function automatic bit legal(input kind_e k, input int slot);
        return slot == 0 ? (k != KMem) : (k != KBr);
    endfunction

    function automatic bit is_nop(input logic [31:0] inst);
        return inst[31:26] == 6'b0;
    endfunction

    task automatic model_step(input logic v0, input logic v1, input logic [31:0] i0,
                              input logic [31:0] i1, input logic st, input logic fl);
        bit rdy;
        rdy = (DEPTH - mq.size()) >= 2;
        if (fl) begin
            mq.delete();
            m_i0 = NOPI; m_i1 = NOPI; m_v0 = 0; m_v1 = 0; m_f = 0;
            return;
        end
        if (!st) begin
            m_i0 = NOPI; m_i1 = NOPI; m_v0 = 0; m_v1 = 0; m_f = 0;
            if (mq.size() >= 2 && legal(kind(mq[0]), 0) && legal(kind(mq[1]), 1)) begin
                m_i0 = mq[0]; m_i1 = mq[1]; m_v0 = 1; m_v1 = 1;
                void'(mq.pop_front()); void'(mq.pop_front());
            end else if (mq.size() >= 2 && legal(kind(mq[1]), 0) && legal(kind(mq[0]), 1)) begin
                m_i0 = mq[1]; m_i1 = mq[0]; m_v0 = 1; m_v1 = 1; m_f = 1;
                void'(mq.pop_front()); void'(mq.pop_front());
            end else if (mq.size() >= 1) begin
                if (legal(kind(mq[0]), 0)) begin
                    m_i0 = mq[0]; m_v0 = 1;
                end else begin
                    m_i1 = mq[0]; m_v1 = 1; m_f = 1;
                end
                void'(mq.pop_front());
            end
        end
        if (rdy && v0) begin
            if (!(SQ && is_nop(i0))) mq.push_back(i0);
            if (v1 && !(SQ && is_nop(i1))) mq.push_back(i1);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] pool [8];
        logic [5:0] op;
        pool[0] = 6'b000000; pool[1] = 6'b000010; pool[2] = 6'b000011; pool[3] = 6'b010010;
        pool[4] = 6'b010011; pool[5] = 6'b100011; pool[6] = 6'b110000; pool[7] = 6'b000100;
        op = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
        return {op, 26'($urandom)};
    endfunction

    initial begin
        drive(0, 0, NOPI, NOPI, 0, 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_out("reset", NOPI, NOPI, 0, 0, 0, 0, 1);

        //       v0 v1 i0    i1    st fl   e0    e1    ev0 ev1 ef occ rdy
        vecs.push_back(mkv(1, 1, ADD1, LW,   0, 0, NOPI, NOPI, 0, 0, 0, 2, 1));
        vecs.push_back(mkv(0, 0, NOPI, NOPI, 0, 0, ADD1, LW,   1, 1, 0, 0, 1));
        vecs.push_back(mkv(1, 1, LW,   SW,   0, 0, NOPI, NOPI, 0, 0, 0, 2, 1));
        vecs.push_back(mkv(0, 0, NOPI, NOPI, 0, 0, NOPI, LW,   0, 1, 1, 1, 1));
        vecs.push_back(mkv(0, 0, NOPI, NOPI, 0, 0, NOPI, SW,   0, 1, 1, 0, 1));
        vecs.push_back(mkv(1, 1, LW,   JMP,  0, 0, NOPI, NOPI, 0, 0, 0, 2, 1));
        vecs.push_back(mkv(1, 1, CMP,  JE,   0, 0, JMP,  LW,   1, 1, 1, 2, 1));
        vecs.push_back(mkv(0, 0, NOPI, NOPI, 0, 0, CMP,  NOPI, 1, 0, 0, 1, 1));
        vecs.push_back(mkv(0, 0, NOPI, NOPI, 0, 0, JE,   NOPI, 1, 0, 0, 0, 1));
        vecs.push_back(mkv(1, 1, ADD1, ADD2, 1, 0, JE,   NOPI, 1, 0, 0, 2, 1));
        vecs.push_back(mkv(1, 1, ADD3, ADD4, 1, 0, JE,   NOPI, 1, 0, 0, 4, 0));
        vecs.push_back(mkv(1, 1, LW,   SW,   1, 0, JE,   NOPI, 1, 0, 0, 4, 0));
        vecs.push_back(mkv(0, 0, NOPI, NOPI, 0, 0, ADD1, ADD2, 1, 1, 0, 2, 1));
        vecs.push_back(mkv(0, 0, NOPI, NOPI, 0, 0, ADD3, ADD4, 1, 1, 0, 0, 1));
        vecs.push_back(mkv(1, 1, ADD1, LW,   1, 0, ADD3, ADD4, 1, 1, 0, 2, 1));
        vecs.push_back(mkv(1, 0, SW,   NOPI, 1, 0, ADD3, ADD4, 1, 1, 0, 3, 0));
        vecs.push_back(mkv(1, 0, ADD2, NOPI, 1, 1, NOPI, NOPI, 0, 0, 0, 0, 1));
        vecs.push_back(mkv(0, 0, NOPI, NOPI, 0, 0, NOPI, NOPI, 0, 0, 0, 0, 1));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].v0, vecs[k].v1, vecs[k].i0, vecs[k].i1, vecs[k].st, vecs[k].fl);
            @(posedge clk); #1;
            chk_out($sformatf("vec%0d", k), vecs[k].e0, vecs[k].e1, vecs[k].ev0, vecs[k].ev1,
                    vecs[k].ef, vecs[k].eocc, vecs[k].erdy);
        end

        // NOP handling: squashed at enqueue when the feature is built in.
        drive(1, 1, NOPI, ADD1, 0, 0);
        @(posedge clk); #1;
        chk("nop.occ", 32'(bus.occupancy), SQ ? 32'd1 : 32'd2);
        drive(0, 0, NOPI, NOPI, 0, 0);
        @(posedge clk); #1;
        if (SQ) chk_out("nop.disp", ADD1, NOPI, 1, 0, 0, 0, 1);
        else    chk_out("nop.disp", NOPI, ADD1, 1, 1, 0, 0, 1);

        // Asynchronous reset mid-run, then randomized traffic against the model.
        rst_n = 1'b0;
        #2;
        chk("areset.occ", 32'(bus.occupancy), 32'd0);
        chk("areset.v0", 32'(bus.valid0_out), 32'd0);
        rst_n = 1'b1;
        mq.delete();
        m_i0 = NOPI; m_i1 = NOPI; m_v0 = 0; m_v1 = 0; m_f = 0;
        @(posedge clk); #1;

        for (int c = 0; c < 600; c++) begin
            logic v0, v1, st, fl;
            logic [31:0] i0, i1;
            v0 = ($urandom_range(0, 3) != 0);
            v1 = v0 && ($urandom_range(0, 2) != 0);
            st = ($urandom_range(0, 4) == 0);
            fl = ($urandom_range(0, 24) == 0);
            i0 = rand_inst();
            i1 = rand_inst();
            drive(v0, v1, i0, i1, st, fl);
            chk($sformatf("rnd%0d.ready", c), 32'(bus.in_ready),
                32'((DEPTH - mq.size()) >= 2));
            model_step(v0, v1, i0, i1, st, fl);
            @(posedge clk); #1;
            chk_out($sformatf("rnd%0d", c), m_i0, m_i1, m_v0, m_v1, m_f, 32'(mq.size()),
                    (DEPTH - mq.size()) >= 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/steer_queue.md
Name: steer_queue

Overview:
- Dual-issue steering unit with an in-order instruction queue between fetch and the two execution pipes.
- Pipe A (slot 0) executes branch-class and ALU instructions; pipe B (slot 1) executes memory-class and ALU instructions.
- Accepts up to two instructions per cycle from fetch and dispatches up to two of the oldest queued instructions per cycle to pipe-legal slots, preserving program order.
- A conflicting pair (two branch-class or two memory-class) is split across cycles in the queue, so fetch does not stall for it.

Parameters:
- INST_WIDTH, 32: instruction width in bits.
- OPCODE_MSB, 31: opcode field MSB.
- OPCODE_LSB, 26: opcode field LSB; the field is 6 bits wide.
- DEPTH, 4: queue entries; a power of 2 and at least 2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid0  in  1  inst0_in is valid.
- in_valid1  in  1  inst1_in is valid; legal only when in_valid0=1.
- inst0_in  in  INST_WIDTH  older fetched instruction.
- inst1_in  in  INST_WIDTH  younger fetched instruction.
- in_ready  out  1  queue has room for two entries.
- stall  in  1  downstream stall; holds the dispatch registers.
- flush  in  1  synchronous queue and output clear (redirect).
- instruction0_out  out  INST_WIDTH  slot 0, pipe A.
- instruction1_out  out  INST_WIDTH  slot 1, pipe B.
- valid0_out  out  1  slot 0 holds a real instruction.
- valid1_out  out  1  slot 1 holds a real instruction.
- first  out  1  1 = slot 1 holds the older instruction of the dispatched group.
- occupancy  out  CNT_W  queued entry count.

Behaviour:
- Reset (rst_n=0, asynchronous): queue empty, pointers 0, occupancy 0.
  - Outputs reset to instruction0_out=instruction1_out=`NOP_INSTRUCTION, valid0_out=valid1_out=0, first=0.
  - in_ready=1 once reset is released.
- Classification by opcode op:
  - op=000000 is DC.
  - op=00xxxx is BR if `OP_CODE_CMP or `OP_CODE_TEST, else DC.
  - op=01xxxx is BR if `OP_CODE_CMPI or `OP_CODE_TESTI, else DC.
  - op=10xxxx is MEM.
  - op=11xxxx is BR.
- Enqueue:
  - in_ready = (DEPTH - occupancy) >= 2. It is combinational from occupancy and independent of in_valid.
  - On a clk edge with in_ready=1 and in_valid0=1: write inst0_in, then inst1_in if in_valid1=1, at the tail in order.
  - Writes are ignored when in_ready=0. Fetch must hold its inputs.
  - Pointers wrap modulo DEPTH.
- Dispatch selection:
  - Combinational from the head entries h0 (oldest) and h1. h1 is considered only when occupancy >= 2.
  - Empty queue: no instructions selected.
  - Single candidate: MEM goes to slot 1 with first=1. BR or DC goes to slot 0 with first=0.
  - Pair BR,BR or MEM,MEM: dispatch h0 only, placed as for a single candidate. h1 stays at the head.
  - Pair MEM,BR / MEM,DC / DC,BR: h1 to slot 0, h0 to slot 1, first=1.
  - Pair BR,MEM / BR,DC / DC,MEM / DC,DC: h0 to slot 0, h1 to slot 1, first=0.
  - Pop count equals the number of instructions selected (0, 1 or 2).
- Dispatch registers, loaded on the clk edge when stall=0:
  - Each slot register gets its selected instruction with valid=1.
  - An unused slot gets `NOP_INSTRUCTION with valid=0.
  - The queue pops at the same edge.
  - stall=1: outputs and head pointer hold; enqueue continues while in_ready=1.
- Latency: an instruction enqueued at edge k appears on the outputs after edge k+1 at the earliest.
- Simultaneous enqueue and pop in one cycle: occupancy += pushed - popped.
  - in_ready is still computed from pre-edge occupancy, so no same-cycle credit is given for the pop.
- flush=1 has priority over stall, enqueue and dispatch:
  - At the edge: queue emptied, occupancy 0, outputs set to the NOP/invalid reset values, first=0, inputs in that cycle discarded.
- Assertion targets:
  - occupancy never exceeds DEPTH.
  - in_valid1 without in_valid0 is a protocol error; inst1_in is ignored in that case.

Optional Feature:
- Macro: STEER_QUEUE_NOP_SQUASH_EN.
- Defined: incoming instructions with opcode 000000 are not written to the queue and consume no entry.
  - If both inputs are NOP, nothing is written.
  - If only inst0_in is NOP, inst1_in is written as a single entry.
- Undefined: NOPs are queued and dispatched like any DC instruction.

Test Plan:
- Reset, then push {ADD, LW} once → after the next edge: slot0=ADD, slot1=LW, valid=1/1, first=0, occupancy 0.
- Push {LW, SW} → edge 1: slot1=LW, slot0=NOP, valid0=0, first=1; edge 2: slot1=SW, first=1. Fetch is never blocked (in_ready=1 throughout).
- Push {LW, JMP} → single edge: slot0=JMP, slot1=LW, first=1; push {CMP, JE} → CMP dispatched, then JE dispatched on the next edge.
- Hold stall=1 while pushing {ADD,ADD} twice with DEPTH=4 → occupancy 4, in_ready=0, third push ignored, outputs frozen. Release stall → dispatch 2 per cycle, in_ready returns to 1.
- Queue at occupancy 3 with flush=1, stall=1 and in_valid0=1 all asserted → after the edge: occupancy 0, outputs NOP with valid=0, input discarded.
- NOP_SQUASH_EN defined: push {NOP, ADD} → occupancy 1, ADD in slot 0. Undefined: occupancy 2, NOP and ADD dispatched together with valid=1/1.
